// File: rtl/exc_sched_if.sv
// Commit-stage / CP0 / fetch signal bundle for the exception scheduler.
// Handshake: redirect_valid is raised by the scheduler and held with a stable
// redirect_pc until a cycle in which redirect_ready is also high; the transfer
// completes on that clock edge and redirect_valid drops the cycle after.
interface exc_sched_if;
    // commit stage
    logic        ws_valid;
    logic        ws_stall;
    logic [31:0] ws_pc;
    logic        ws_bd;
    logic        ws_adel_if;
    logic        ws_ri;
    logic        ws_ov;
    logic        ws_sys;
    logic        ws_brk;
    logic        ws_adel_ld;
    logic        ws_ades_st;
    logic        ws_eret;
    logic        ws_mtc0_sc;
    logic [31:0] ws_badvaddr;
    logic        ws_kill;
    // CP0
    logic        int_response;
    logic [31:0] cp0_status;
    logic [31:0] cp0_epc;
    logic        exc_valid;
    logic [4:0]  exc_excode;
    logic        exc_bd;
    logic [31:0] exc_epc;
    logic [31:0] exc_badvaddr;
    logic        exc_eret;
    // pipeline control / fetch
    logic        flush;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        redirect_ready;

    // pipeline/CP0/fetch side
    modport master (
        output ws_valid, ws_stall, ws_pc, ws_bd, ws_adel_if, ws_ri, ws_ov,
               ws_sys, ws_brk, ws_adel_ld, ws_ades_st, ws_eret, ws_mtc0_sc,
               ws_badvaddr, int_response, cp0_status, cp0_epc, redirect_ready,
        input  ws_kill, exc_valid, exc_excode, exc_bd, exc_epc, exc_badvaddr,
               exc_eret, flush, redirect_valid, redirect_pc
    );

    // scheduler side
    modport slave (
        input  ws_valid, ws_stall, ws_pc, ws_bd, ws_adel_if, ws_ri, ws_ov,
               ws_sys, ws_brk, ws_adel_ld, ws_ades_st, ws_eret, ws_mtc0_sc,
               ws_badvaddr, int_response, cp0_status, cp0_epc, redirect_ready,
        output ws_kill, exc_valid, exc_excode, exc_bd, exc_epc, exc_badvaddr,
               exc_eret, flush, redirect_valid, redirect_pc
    );
endinterface

// File: rtl/exc_sched.sv
// Commit-stage exception/interrupt scheduler. Picks the highest-priority
// event of the retiring instruction, posts a one-cycle CP0 update, then
// flushes and holds a redirect to fetch until it is accepted. Interrupts are
// held off for a few cycles after an MTC0 to Status/Cause retires.
module exc_sched #(
    parameter logic [31:0] EXC_VEC_NORMAL = 32'h8000_0180,
    parameter logic [31:0] EXC_VEC_BOOT   = 32'hBFC0_0380,
    parameter int          INT_HOLDOFF    = 2
) (
    input  logic        clk,
    input  logic        resetn,
    exc_sched_if.slave  bus,
    output logic        o_dbg_state
);
    localparam int HW = (INT_HOLDOFF > 1) ? $clog2(INT_HOLDOFF + 1) : 1;

    typedef enum logic {IDLE = 1'b0, REDIR = 1'b1} state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [HW-1:0] r_holdoff;
    logic        r_exc_valid;
    logic [4:0]  r_exc_excode;
    logic        r_exc_bd;
    logic [31:0] r_exc_epc;
    logic [31:0] r_exc_badvaddr;
    logic        r_exc_eret;
    logic [31:0] r_redirect_pc;

    logic        w_commit;
    logic        w_int_ok;
    logic        w_any_fault;
    logic        w_detect;
    logic        w_is_eret;
    logic [4:0]  w_code;
    logic [31:0] w_bva;
    logic [31:0] w_epc;
    logic [31:0] w_target;
    logic        w_flush;

    // resetn gates the commit so ws_kill is also low while reset is held
    assign w_commit    = resetn & bus.ws_valid & ~bus.ws_stall & (r_state == IDLE);
    assign w_int_ok    = bus.int_response & (r_holdoff == '0);
    assign w_any_fault = bus.ws_adel_if | bus.ws_ri | bus.ws_ov | bus.ws_sys |
                         bus.ws_brk | bus.ws_adel_ld | bus.ws_ades_st;
    assign w_detect    = w_commit & (w_int_ok | w_any_fault | bus.ws_eret);
    assign w_epc       = bus.ws_bd ? (bus.ws_pc - 32'd4) : bus.ws_pc;

    // priority select of excode/BadVAddr; eret only when nothing else applies
    always_comb begin
        w_code    = 5'h00;
        w_bva     = 32'h0;
        w_is_eret = 1'b0;
        if (w_int_ok) begin
            w_code = 5'h00;
        end else if (bus.ws_adel_if) begin
            w_code = 5'h04;
            w_bva  = bus.ws_pc;
        end else if (bus.ws_ri) begin
            w_code = 5'h0A;
        end else if (bus.ws_ov) begin
            w_code = 5'h0C;
        end else if (bus.ws_sys) begin
            w_code = 5'h08;
        end else if (bus.ws_brk) begin
            w_code = 5'h09;
        end else if (bus.ws_adel_ld) begin
            w_code = 5'h04;
            w_bva  = bus.ws_badvaddr;
        end else if (bus.ws_ades_st) begin
            w_code = 5'h05;
            w_bva  = bus.ws_badvaddr;
        end else begin
            w_is_eret = bus.ws_eret;
        end
    end

    // redirect target: EPC for eret, otherwise the BEV-selected vector
    always_comb begin
        w_target = EXC_VEC_NORMAL;
        if (w_is_eret) begin
            w_target = bus.cp0_epc;
        end else if (bus.cp0_status[22]) begin
            w_target = EXC_VEC_BOOT;
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next state and flush/redirect outputs
    always_comb begin
        w_state_nxt = r_state;
        w_flush     = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_detect) begin
                    w_state_nxt = REDIR;
                end
            end
            REDIR: begin
                w_flush = 1'b1;
                if (bus.redirect_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // one-cycle CP0 update strobe with its payload captured on detection
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_exc_valid    <= 1'b0;
            r_exc_excode   <= 5'h00;
            r_exc_bd       <= 1'b0;
            r_exc_epc      <= 32'h0;
            r_exc_badvaddr <= 32'h0;
            r_exc_eret     <= 1'b0;
        end else begin
            r_exc_valid <= w_detect;
            if (w_detect) begin
                r_exc_excode   <= w_code;
                r_exc_bd       <= w_is_eret ? 1'b0 : bus.ws_bd;
                r_exc_epc      <= w_epc;
                r_exc_badvaddr <= w_bva;
                r_exc_eret     <= w_is_eret;
            end
        end
    end

    // redirect target captured in the detection cycle, stable through REDIR
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_redirect_pc <= 32'h0;
        end else if (w_detect) begin
            r_redirect_pc <= w_target;
        end
    end

    // interrupt holdoff after a clean MTC0 to Status/Cause; saturates at 0
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_holdoff <= '0;
        end else if (w_commit && !w_detect && bus.ws_mtc0_sc) begin
            r_holdoff <= HW'(INT_HOLDOFF);
        end else if (r_holdoff != '0) begin
            r_holdoff <= r_holdoff - 1'b1;
        end
    end

    assign bus.ws_kill        = w_detect;
    assign bus.exc_valid      = r_exc_valid;
    assign bus.exc_excode     = r_exc_excode;
    assign bus.exc_bd         = r_exc_bd;
    assign bus.exc_epc        = r_exc_epc;
    assign bus.exc_badvaddr   = r_exc_badvaddr;
    assign bus.exc_eret       = r_exc_eret;
    assign bus.flush          = w_flush;
    assign bus.redirect_valid = w_flush;
    assign bus.redirect_pc    = r_redirect_pc;
    assign o_dbg_state        = (r_state == REDIR);

endmodule

// File: tb/tb_exc_sched.sv
// Bench for exc_sched: directed scenarios with literal expectations plus a
// per-cycle comparison against a table-driven behavioural model.
module tb_exc_sched;
  localparam logic [31:0] VEC_N = 32'h8000_0180;
  localparam logic [31:0] VEC_B = 32'hBFC0_0380;
  localparam int HOLD = 2;

  logic clk;
  logic resetn;
  logic dbg_state;
  int n_vec;
  int n_err;

  exc_sched_if bus();

  exc_sched #(.EXC_VEC_NORMAL(VEC_N), .EXC_VEC_BOOT(VEC_B), .INT_HOLDOFF(HOLD)) dut (
    .clk(clk),
    .resetn(resetn),
    .bus(bus),
    .o_dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  // record: {eret, excode[4:0], bd, epc[31:0], badvaddr[31:0]}
  logic [70:0] exp_q[$];
  bit          m_redir;
  int          m_hold;
  logic [31:0] m_redir_pc;
  bit          m_exc_v;

  function automatic void model_eval(output bit ev, output logic [70:0] rec,
                                     output logic [31:0] tgt);
    bit          flags[8];
    logic [4:0]  codes[8];
    bit          commit;
    bit          found;
    int          idx;
    logic [31:0] epc;
    logic [31:0] bva;
    codes = '{5'h00, 5'h04, 5'h0A, 5'h0C, 5'h08, 5'h09, 5'h04, 5'h05};
    flags = '{bus.int_response && (m_hold == 0), bus.ws_adel_if, bus.ws_ri,
              bus.ws_ov, bus.ws_sys, bus.ws_brk, bus.ws_adel_ld, bus.ws_ades_st};
    commit = bus.ws_valid && !bus.ws_stall && !m_redir;
    found = 0;
    idx = 0;
    for (int i = 0; i < 8; i++) begin
      if (flags[i] && !found) begin
        found = 1;
        idx = i;
      end
    end
    ev  = commit && (found || bus.ws_eret);
    epc = bus.ws_bd ? bus.ws_pc - 32'd4 : bus.ws_pc;
    bva = 32'h0;
    if (found && idx == 1) bva = bus.ws_pc;
    if (found && (idx == 6 || idx == 7)) bva = bus.ws_badvaddr;
    if (found) begin
      rec = {1'b0, codes[idx], bus.ws_bd, epc, bva};
      tgt = bus.cp0_status[22] ? VEC_B : VEC_N;
    end else begin
      rec = {1'b1, 5'h00, 1'b0, epc, 32'h0};
      tgt = bus.cp0_epc;
    end
  endfunction

  // model state advance on each clock edge
  always @(posedge clk or negedge resetn) begin
    bit ev;
    logic [70:0] rec;
    logic [31:0] tgt;
    if (!resetn) begin
      m_redir    <= 0;
      m_hold     <= 0;
      m_redir_pc <= 32'h0;
      m_exc_v    <= 0;
      exp_q.delete();
    end else begin
      model_eval(ev, rec, tgt);
      m_exc_v <= ev;
      if (ev) begin
        exp_q.push_back(rec);
        m_redir_pc <= tgt;
        m_redir <= 1;
      end else if (m_redir && bus.redirect_ready) begin
        m_redir <= 0;
      end
      if (bus.ws_valid && !bus.ws_stall && !m_redir && !ev && bus.ws_mtc0_sc)
        m_hold <= HOLD;
      else if (m_hold > 0)
        m_hold <= m_hold - 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // per-cycle comparison against the model
  always @(negedge clk) begin
    bit ev;
    logic [70:0] rec;
    logic [31:0] tgt;
    logic [70:0] e;
    if (resetn) begin
      model_eval(ev, rec, tgt);
      chk("m_kill", 32'(bus.ws_kill), 32'(ev));
      chk("m_flush", 32'(bus.flush), 32'(m_redir));
      chk("m_rvalid", 32'(bus.redirect_valid), 32'(m_redir));
      chk("m_state", 32'(dbg_state), 32'(m_redir));
      if (m_redir) chk("m_rpc", bus.redirect_pc, m_redir_pc);
      chk("m_exc_valid", 32'(bus.exc_valid), 32'(m_exc_v));
      if (m_exc_v && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("m_eret", 32'(bus.exc_eret), 32'(e[70]));
        chk("m_excode", 32'(bus.exc_excode), 32'(e[69:65]));
        chk("m_bd", 32'(bus.exc_bd), 32'(e[64]));
        chk("m_epc", bus.exc_epc, e[63:32]);
        chk("m_bva", bus.exc_badvaddr, e[31:0]);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_ws();
    bus.ws_valid    = 0;
    bus.ws_stall    = 0;
    bus.ws_pc       = 32'h0;
    bus.ws_bd       = 0;
    bus.ws_adel_if  = 0;
    bus.ws_ri       = 0;
    bus.ws_ov       = 0;
    bus.ws_sys      = 0;
    bus.ws_brk      = 0;
    bus.ws_adel_ld  = 0;
    bus.ws_ades_st  = 0;
    bus.ws_eret     = 0;
    bus.ws_mtc0_sc  = 0;
    bus.ws_badvaddr = 32'h0;
    bus.int_response = 0;
  endtask

  task automatic commit_at(input logic [31:0] pc, input logic bd);
    bus.ws_valid = 1;
    bus.ws_pc    = pc;
    bus.ws_bd    = bd;
  endtask

  // accept the redirect: ready high for one edge
  task automatic handshake();
    bus.redirect_ready = 1;
    tick();
    bus.redirect_ready = 0;
    @(negedge clk);
    chk("hs_rvalid_low", 32'(bus.redirect_valid), 32'h0);
    chk("hs_flush_low", 32'(bus.flush), 32'h0);
    tick();
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    n_vec = 0;
    n_err = 0;
    resetn = 0;
    clear_ws();
    bus.cp0_status = 32'h0;
    bus.cp0_epc = 32'h0;
    bus.redirect_ready = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_exc_valid", 32'(bus.exc_valid), 32'h0);
    chk("rst_rvalid", 32'(bus.redirect_valid), 32'h0);
    chk("rst_rpc", bus.redirect_pc, 32'h0);
    chk("rst_flush", 32'(bus.flush), 32'h0);
    #1 resetn = 1;
    tick();

    // overflow, BEV=0
    commit_at(32'h8000_1000, 0);
    bus.ws_ov = 1;
    @(negedge clk);
    chk("ov_kill", 32'(bus.ws_kill), 32'h1);
    tick();
    clear_ws();
    @(negedge clk);
    chk("ov_exc_valid", 32'(bus.exc_valid), 32'h1);
    chk("ov_excode", 32'(bus.exc_excode), 32'h0C);
    chk("ov_epc", bus.exc_epc, 32'h8000_1000);
    chk("ov_rpc", bus.redirect_pc, 32'h8000_0180);
    tick();
    @(negedge clk);
    chk("ov_pulse_end", 32'(bus.exc_valid), 32'h0);
    chk("ov_rvalid_held", 32'(bus.redirect_valid), 32'h1);
    handshake();

    // delay-slot load fault
    commit_at(32'h8000_2004, 1);
    bus.ws_adel_ld = 1;
    bus.ws_badvaddr = 32'h0000_1235;
    tick();
    clear_ws();
    @(negedge clk);
    chk("ld_excode", 32'(bus.exc_excode), 32'h04);
    chk("ld_bd", 32'(bus.exc_bd), 32'h1);
    chk("ld_epc", bus.exc_epc, 32'h8000_2000);
    chk("ld_bva", bus.exc_badvaddr, 32'h0000_1235);
    handshake();

    // interrupt beats sys + adel_if
    commit_at(32'h8000_4000, 0);
    bus.int_response = 1;
    bus.ws_sys = 1;
    bus.ws_adel_if = 1;
    tick();
    clear_ws();
    @(negedge clk);
    chk("int_excode", 32'(bus.exc_excode), 32'h00);
    chk("int_bva", bus.exc_badvaddr, 32'h0);
    handshake();
    // same without the interrupt
    commit_at(32'h8000_4000, 0);
    bus.ws_sys = 1;
    bus.ws_adel_if = 1;
    tick();
    clear_ws();
    @(negedge clk);
    chk("if_excode", 32'(bus.exc_excode), 32'h04);
    chk("if_bva", bus.exc_badvaddr, 32'h8000_4000);
    handshake();

    // eret with a slow fetch; commits during REDIR are ignored
    commit_at(32'h8000_5000, 0);
    bus.ws_eret = 1;
    bus.cp0_epc = 32'h8000_3000;
    tick();
    clear_ws();
    bus.cp0_epc = 32'h0;
    @(negedge clk);
    chk("eret_valid", 32'(bus.exc_valid), 32'h1);
    chk("eret_flag", 32'(bus.exc_eret), 32'h1);
    chk("eret_excode", 32'(bus.exc_excode), 32'h00);
    chk("eret_rpc", bus.redirect_pc, 32'h8000_3000);
    tick();
    for (int i = 0; i < 5; i++) begin
      commit_at(32'h8000_6000 + 32'(i * 4), 0);
      bus.ws_ov = 1;
      @(negedge clk);
      chk("eret_hold_rvalid", 32'(bus.redirect_valid), 32'h1);
      chk("eret_hold_flush", 32'(bus.flush), 32'h1);
      chk("eret_hold_kill", 32'(bus.ws_kill), 32'h0);
      chk("eret_hold_rpc", bus.redirect_pc, 32'h8000_3000);
      tick();
    end
    clear_ws();
    handshake();

    // stalled commit is not sampled
    commit_at(32'h8000_7000, 0);
    bus.ws_ov = 1;
    bus.ws_stall = 1;
    @(negedge clk);
    chk("stall_kill", 32'(bus.ws_kill), 32'h0);
    tick();
    clear_ws();

    // MTC0 holdoff, BEV=1
    bus.cp0_status = 32'h0040_0000;
    commit_at(32'h8000_8000, 0);
    bus.ws_mtc0_sc = 1;
    @(negedge clk);
    chk("mtc0_kill", 32'(bus.ws_kill), 32'h0);
    tick();
    bus.ws_mtc0_sc = 0;
    bus.int_response = 1;
    for (int i = 0; i < 3; i++) begin
      bus.ws_pc = 32'h8000_8004 + 32'(i * 4);
      @(negedge clk);
      chk("hold_kill", 32'(bus.ws_kill), (i == 2) ? 32'h1 : 32'h0);
      tick();
    end
    clear_ws();
    @(negedge clk);
    chk("hold_excode", 32'(bus.exc_excode), 32'h00);
    chk("hold_epc", bus.exc_epc, 32'h8000_800C);
    chk("hold_rpc_bev", bus.redirect_pc, 32'hBFC0_0380);
    handshake();
    bus.cp0_status = 32'h0;

    // random traffic, model-checked every cycle
    for (int i = 0; i < 60; i++) begin
      bus.ws_valid    = 1'($urandom_range(0, 1));
      bus.ws_stall    = ($urandom_range(0, 5) == 0);
      bus.ws_pc       = {$urandom_range(0, 32'hFFFF), 2'b00} + 32'h8000_0000;
      bus.ws_bd       = 1'($urandom_range(0, 1));
      bus.ws_adel_if  = ($urandom_range(0, 9) == 0);
      bus.ws_ri       = ($urandom_range(0, 9) == 0);
      bus.ws_ov       = ($urandom_range(0, 9) == 0);
      bus.ws_sys      = ($urandom_range(0, 9) == 0);
      bus.ws_brk      = ($urandom_range(0, 9) == 0);
      bus.ws_adel_ld  = ($urandom_range(0, 9) == 0);
      bus.ws_ades_st  = ($urandom_range(0, 9) == 0);
      bus.ws_eret     = ($urandom_range(0, 9) == 0);
      bus.ws_mtc0_sc  = ($urandom_range(0, 3) == 0);
      bus.ws_badvaddr = $urandom;
      bus.int_response = ($urandom_range(0, 3) == 0);
      bus.cp0_status  = $urandom_range(0, 1) ? 32'h0040_0000 : 32'h0;
      bus.cp0_epc     = $urandom;
      bus.redirect_ready = 1'($urandom_range(0, 1));
      tick();
    end
    clear_ws();
    bus.redirect_ready = 1;
    tick();
    tick();
    bus.redirect_ready = 0;

    // reset in the middle of REDIR
    commit_at(32'h8000_9000, 0);
    bus.ws_brk = 1;
    tick();
    clear_ws();
    #1;
    chk("pre_rst_state", 32'(dbg_state), 32'h1);
    resetn = 0;
    #1;
    chk("mid_rst_rvalid", 32'(bus.redirect_valid), 32'h0);
    chk("mid_rst_flush", 32'(bus.flush), 32'h0);
    chk("mid_rst_exc_valid", 32'(bus.exc_valid), 32'h0);
    chk("mid_rst_rpc", bus.redirect_pc, 32'h0);
    chk("mid_rst_excode", 32'(bus.exc_excode), 32'h0);
    chk("mid_rst_state", 32'(dbg_state), 32'h0);
    tick();
    resetn = 1;
    tick();
    @(negedge clk);
    chk("post_rst_rvalid", 32'(bus.redirect_valid), 32'h0);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
